// File: rtl/spi_exch_word.sv
// spi_exch_word: full-duplex SPI master word shifter (CPOL/CPHA, MSB/LSB order, SCLK divider); define SPI_EXCH_CS_EN for chip select with trailing hold
module spi_exch_word #(
  parameter int WORD_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              msb_lsb_sel_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [WORD_W-1:0] tx_data_i,
  output logic              rx_valid_o,
  output logic [WORD_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              mosi_o,
`ifdef SPI_EXCH_CS_EN
  output logic              cs_n_o,
  input  logic              cs_keep_i,
`endif
  input  logic              miso_i
);
  localparam int EW = $clog2(2 * WORD_W);
  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;
  state_t state, state_d;
  logic rdy_q, cpol_q, cpha_q, lsb_q;
  logic [DIV_W-1:0] div_q, cnt;
  logic [EW-1:0] edges;
  logic [WORD_W-1:0] tx_sr, rx_sr, rx_nxt, rx_fin, tx_ord;
  logic acc, wrap, last, smp, drv, done;
  function automatic logic [WORD_W-1:0] rev(input logic [WORD_W-1:0] v);
    for (int i = 0; i < WORD_W; i++) rev[i] = v[WORD_W-1-i];
  endfunction
  assign tx_ready_o = rdy_q && state == IDLE;
  assign busy_o = state != IDLE;
  assign acc = tx_valid_i && tx_ready_o;
  assign wrap = cnt == div_q;
  assign last = state == SHIFT && wrap && edges == EW'(2 * WORD_W - 1);
  assign smp = state == SHIFT && wrap && (!edges[0] ^ cpha_q);
  assign drv = state == SHIFT && wrap && !(!edges[0] ^ cpha_q) && !last;
  assign rx_nxt = {miso_i, rx_sr[WORD_W-1:1]};
  assign rx_fin = smp ? rx_nxt : rx_sr;
  assign tx_ord = msb_lsb_sel_i ? tx_data_i : rev(tx_data_i);
`ifdef SPI_EXCH_CS_EN
  logic cs_keep_q;
  assign done = state == TRAIL && wrap;
`else
  assign done = last;
`endif
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_d;
  always_comb begin
    state_d = IDLE;
    case (state)
      IDLE:  state_d = acc ? SHIFT : IDLE;
`ifdef SPI_EXCH_CS_EN
      SHIFT: state_d = last ? TRAIL : SHIFT;
      TRAIL: state_d = wrap ? IDLE : TRAIL;
`else
      SHIFT: state_d = last ? IDLE : SHIFT;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      rdy_q <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o <= '0;
      sclk_o <= 1'b0;
      mosi_o <= 1'b1;
      cnt <= '0;
      edges <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q <= 1'b0;
      div_q <= '0;
`ifdef SPI_EXCH_CS_EN
      cs_n_o <= 1'b1;
      cs_keep_q <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b1;
      rx_valid_o <= done;
      rx_data_o <= done ? (lsb_q ? rx_fin : rev(rx_fin)) : rx_data_o;
      cnt <= (state == IDLE || wrap) ? '0 : cnt + DIV_W'(1);
      edges <= state == IDLE ? '0 : edges + EW'(wrap);
      sclk_o <= state == IDLE ? cpol_i : last ? cpol_q : sclk_o ^ (state == SHIFT && wrap);
      mosi_o <= (acc && !cpha_i) ? tx_ord[0] : last ? 1'b1 : drv ? tx_sr[0] : mosi_o;
      tx_sr <= acc ? (cpha_i ? tx_ord : tx_ord >> 1) : drv ? tx_sr >> 1 : tx_sr;
      rx_sr <= acc ? '0 : smp ? rx_nxt : rx_sr;
      cpol_q <= acc ? cpol_i : cpol_q;
      cpha_q <= acc ? cpha_i : cpha_q;
      lsb_q <= acc ? msb_lsb_sel_i : lsb_q;
      div_q <= acc ? div_i : div_q;
`ifdef SPI_EXCH_CS_EN
      cs_keep_q <= acc ? cs_keep_i : cs_keep_q;
      cs_n_o <= acc ? 1'b0 : done ? !cs_keep_q : cs_n_o;
`endif
    end
endmodule

// File: tb/tb_spi_exch_word.sv
// tb_spi_exch_word: randomized and directed SPI exchanges checked every cycle against a behavioural timing model
module tb_spi_exch_word;
  localparam int W = 8;
`ifdef SPI_EXCH_CS_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int LA = (2 * W + CS) * 2;
  localparam int LB = (2 * W + CS) * 1;
  localparam int LC = (2 * W + CS) * 4;
  logic clk = 0, rst = 1, cpol = 0, cpha = 0, lsb = 0, tx_valid = 0, miso_drv = 0, loop = 0, keep = 0;
  logic [7:0] div = 0;
  logic [W-1:0] tx_data = 0, slave_w = 0;
  logic tx_ready, rx_valid, busy, sclk, mosi, miso;
  logic [W-1:0] rx_data;
`ifdef SPI_EXCH_CS_EN
  logic cs_n;
`endif
  int checks = 0, errors = 0;
  logic mon = 0, act = 0, acc_pend = 0, rst_seen = 1, ploop = 0, pcpol = 0, pcpha = 0, pkeep = 0, cs_hold = 0, cpol_prev = 0, mr;
  logic s_loop, s_cpol, s_cpha, s_keep;
  int n, d, L, sh, e, s_d;
  logic [W-1:0] pord, psl, pexp, s_ord, s_sl, s_exp, exp_rx = 0, mseq = 0;
  logic [W-1:0] rxq[$];
  always #5 clk = ~clk;
  assign miso = ploop ? mosi : miso_drv;
  spi_exch_word #(.WORD_W(W), .DIV_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .cpol_i(cpol), .cpha_i(cpha), .msb_lsb_sel_i(lsb), .div_i(div),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data), .rx_valid_o(rx_valid),
    .rx_data_o(rx_data), .busy_o(busy), .sclk_o(sclk), .mosi_o(mosi),
`ifdef SPI_EXCH_CS_EN
    .cs_n_o(cs_n), .cs_keep_i(keep),
`endif
    .miso_i(miso)
  );
  function automatic logic [W-1:0] ord(input logic [W-1:0] v, input logic ls);
    ord = v;
    if (!ls) for (int i = 0; i < W; i++) ord[i] = v[W-1-i];
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask
  always @(negedge clk) if (rx_valid) rxq.push_back(rx_data);
  always @(negedge clk) if (mon) begin
    mr = 1'b0;
    if (rst_seen) begin
      chk("rst_ready", tx_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rxv", rx_valid, 0);
      chk("rst_rxd", rx_data, 0);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 1);
`ifdef SPI_EXCH_CS_EN
      chk("rst_cs", cs_n, 1);
`endif
      act = 0; acc_pend = 0; exp_rx = 0; cs_hold = 0;
    end else begin
      if (acc_pend) begin
        act = 1; n = 0; acc_pend = 0; mseq = 0;
        pord = s_ord; psl = s_sl; pexp = s_exp; ploop = s_loop; pcpol = s_cpol; pcpha = s_cpha; pkeep = s_keep; d = s_d;
        L = (2 * W + CS) * (d + 1);
        sh = 2 * W * (d + 1);
      end else if (act) n++;
      if (act) begin
        e = n / (d + 1);
        chk("busy", busy, n < L);
        chk("ready", tx_ready, n == L);
        chk("rx_valid", rx_valid, n == L);
        chk("sclk", sclk, n >= sh ? pcpol : pcpol ^ (e % 2 == 1));
        chk("mosi", mosi, n >= sh ? 1'b1 : pcpha ? (e == 0 ? 1'b1 : pord[(e - 1) / 2]) : pord[e / 2]);
`ifdef SPI_EXCH_CS_EN
        chk("cs_n", cs_n, n < L ? 1'b0 : !pkeep);
`endif
        if (n < sh) begin
          miso_drv = psl[pcpha ? (e == 0 ? 0 : (e - 1) / 2) : e / 2];
          if (n % (d + 1) == d && ((e % 2 == 0) != pcpha)) mseq = {mseq[W-2:0], mosi};
        end
        if (n == L) begin
          chk("rx_data", rx_data, pexp);
          exp_rx = pexp; cs_hold = pkeep; act = 0; mr = 1;
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_ready", tx_ready, 1);
        chk("idle_rxv", rx_valid, 0);
        chk("idle_sclk", sclk, cpol_prev);
        chk("idle_mosi", mosi, 1);
        chk("idle_rxd", rx_data, exp_rx);
`ifdef SPI_EXCH_CS_EN
        chk("idle_cs", cs_n, !cs_hold);
`endif
        mr = 1;
      end
    end
    rst_seen = rst;
    if (tx_valid && mr && !rst) begin
      acc_pend = 1;
      s_ord = ord(tx_data, lsb); s_sl = ord(slave_w, lsb); s_exp = loop ? tx_data : slave_w;
      s_loop = loop; s_cpol = cpol; s_cpha = cpha; s_keep = keep; s_d = int'(div);
    end
    cpol_prev = cpol;
  end
  task automatic offer(input logic [W-1:0] data, input logic [W-1:0] sl, input logic lp, input logic pol,
                       input logic pha, input logic ls, input int dv, input logic kp);
    tx_data = data; slave_w = sl; loop = lp; cpol = pol; cpha = pha; lsb = ls; div = 8'(dv); keep = kp; tx_valid = 1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        @(posedge clk); #2;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL accept_timeout at %0t", $time);
    @(posedge clk); #2;
  endtask
  task automatic wait_rx(output int lat, output logic [W-1:0] dat);
    lat = -1; dat = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        lat = i; dat = rx_data;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL rx_timeout at %0t", $time);
    end
    @(posedge clk); #2;
  endtask
  initial begin
    int lat, sz;
    logic [W-1:0] dat;
    @(posedge clk); #2; mon = 1;
    @(posedge clk); #2; rst = 0;
    repeat (3) @(posedge clk); #2;
    offer(8'hA5, 8'h00, 1, 0, 0, 0, 1, 0); tx_valid = 0;
    wait_rx(lat, dat);
    chk("A_lat", lat, LA); chk("A_rx", dat, 8'hA5); chk("A_mosi_seq", mseq, 8'hA5); chk("A_sclk_idle", sclk, 0);
    offer(8'h3C, 8'h81, 0, 1, 1, 1, 0, 0); tx_valid = 0;
    wait_rx(lat, dat);
    chk("B_lat", lat, LB); chk("B_rx", dat, 8'h81); chk("B_mosi_seq", mseq, 8'h3C); chk("B_sclk_idle", sclk, 1);
    offer(8'hEF, 8'h00, 1, 0, 1, 0, 3, 0); tx_valid = 0;
    cpol = 1; cpha = 0; lsb = 1; div = 0; tx_data = 8'h00;
    wait_rx(lat, dat);
    chk("C_lat", lat, LC); chk("C_rx", dat, 8'hEF);
    sz = rxq.size();
    offer(8'h11, 8'h00, 1, 1, 0, 0, 1, 0);
    offer(8'h22, 8'h00, 1, 1, 0, 0, 1, 0); tx_valid = 0;
    wait_rx(lat, dat);
    chk("D_lat2", lat, LA); chk("D_rx1", rxq[sz], 8'h11); chk("D_rx2", rxq[sz + 1], 8'h22);
    offer(8'h5A, 8'h00, 1, 0, 0, 0, 1, 0); tx_valid = 0;
    repeat (10) @(posedge clk);
    #2; rst = 1;
    @(posedge clk); #2; rst = 0;
    sz = rxq.size();
    @(negedge clk);
    chk("E_busy", busy, 0); chk("E_mosi", mosi, 1); chk("E_rxd", rx_data, 0); chk("E_ready0", tx_ready, 0);
    @(negedge clk);
    chk("E_ready1", tx_ready, 1);
    repeat (40) @(negedge clk);
    chk("E_norx", rxq.size(), sz);
    @(posedge clk); #2;
`ifdef SPI_EXCH_CS_EN
    offer(8'h12, 8'h00, 1, 0, 0, 0, 1, 1); tx_valid = 0;
    wait_rx(lat, dat);
    chk("F_cs_kept", cs_n, 0);
    offer(8'h34, 8'h00, 1, 0, 0, 0, 1, 0); tx_valid = 0;
    wait_rx(lat, dat);
    chk("F_cs_end", cs_n, 1); chk("F_rx", dat, 8'h34);
`endif
    for (int k = 0; k < 40; k++) begin
      offer(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom));
      tx_valid = 0;
      cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom); div = 8'($urandom_range(0, 3));
      tx_data = W'($urandom); keep = 1'($urandom);
      wait_rx(lat, dat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2;
    end
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_exch_word.md
Name: spi_exch_word

Overview:
- Parametrised successor to the byte-exchange engine: full-duplex SPI master shifter with configurable word width, all four SPI modes (CPOL/CPHA), runtime MSB/LSB order and an internal SCLK divider.
- It generates SCLK itself; it does not follow an external sclk.
- Sits between the AXI-lite register/FIFO front end (valid/ready word interface) and the SPI pads.

Parameters:
- WORD_W, 8, bits per exchanged word (2..32).
- DIV_W, 8, width of the half-period divider input.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, synchronous, active-high
- cpol_i  input  1  SCLK idle level
- cpha_i  input  1  0: sample on leading edge; 1: sample on trailing edge
- msb_lsb_sel_i  input  1  0 = MSB first, 1 = LSB first
- div_i  input  DIV_W  SCLK half period = div_i+1 clk cycles
- tx_valid_i  input  1  word offered
- tx_ready_o  output  1  engine can accept a word
- tx_data_i  input  WORD_W  word to transmit
- rx_valid_o  output  1  one-cycle pulse: rx_data_o updated
- rx_data_o  output  WORD_W  received word, bit-ordered per msb_lsb_sel
- busy_o  output  1  transfer in progress
- sclk_o  output  1  SPI clock
- mosi_o  output  1  SPI data out
- miso_i  input  1  SPI data in

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: tx_ready_o=0 for the reset cycle, then 1 in IDLE; rx_valid_o=0; rx_data_o=0; busy_o=0; sclk_o=0; mosi_o=1.
- After reset, sclk_o follows cpol_i while in IDLE.
- States: IDLE, SHIFT (plus TRAIL with CS_EN). Encoding is unspecified. Unused encodings return to IDLE.
- Handshake:
  - tx_ready_o = (state==IDLE).
  - Accept on a clk edge with tx_valid_i & tx_ready_o.
  - At acceptance, latch cpol, cpha, msb_lsb_sel, div and tx_data. Input changes during a transfer are ignored.
- Acceptance actions:
  - Load the shift register with tx_data, reversed if MSB-first, so bit 0 is always shifted first.
  - busy_o=1. Clear the half-period counter and the edge counter.
  - CPHA=0: mosi_o = first bit immediately.
  - CPHA=1: mosi_o holds until the first edge.
- SHIFT:
  - The half-period counter counts 0..div. On wrap, sclk_o toggles and the edge counter increments.
  - Edge k (1..2*WORD_W) is registered (div+1)*k cycles after the acceptance edge.
  - CPHA=0: odd edges sample miso_i into the receive register; even edges (except the last) drive the next bit onto mosi_o.
  - CPHA=1: odd edges drive the next bit; even edges sample.
- Completion (edge 2*WORD_W):
  - On the same clk edge: sclk_o back to latched cpol, mosi_o=1, busy_o=0, rx_valid_o=1 for one cycle.
  - rx_data_o = received bits, first-received bit placed at MSB if MSB-first, else at LSB. State returns to IDLE, so tx_ready_o=1.
- Total latency from acceptance to rx_valid_o: 2*WORD_W*(div+1) cycles. W=8, div=1 gives 32.
- Back-to-back: a word accepted in the rx_valid_o cycle is legal. Its first edge follows div+1 cycles later, which guarantees a minimum half-period idle.
- div_i=0: SCLK = clk/2, which is legal.
- Reset mid-transfer: on the next edge all outputs take reset values. Partial receive data is discarded and no rx_valid_o pulse is produced.
- rx_data_o holds its value until the next completion.

Optional Feature:
- Macro: SPI_EXCH_CS_EN.
- When defined, adds ports:
  - cs_n_o (output, 1, reset 1).
  - cs_keep_i (input, 1, latched at acceptance).
- cs_n_o goes low on the acceptance edge.
- After the final edge, a TRAIL state holds cs_n_o low for div+1 cycles. Then cs_n_o returns to 1 unless the latched cs_keep=1, and rx_valid_o pulses on the TRAIL exit. Latency therefore becomes (2*WORD_W+1)*(div+1).
- With cs_keep=1, cs_n_o stays low through IDLE until the next word, which must have cs_keep=0, ends the frame.
- Without the macro: no cs_n_o, no TRAIL state; timing is as in Behaviour.

Test Plan:
- Mode 0, MSB first, div=1, WORD_W=8, tx 0xA5, miso looped from mosi -> rx_valid_o exactly 32 cycles after acceptance, rx_data_o=0xA5, mosi sequence 1,0,1,0,0,1,0,1, sclk idles 0.
- Mode 3, LSB first, div=0, tx 0x3C, slave model returns 0x81 LSB-first on the trailing-edge sample -> rx_data_o=0x81, mosi sequence 0,0,1,1,1,1,0,0, sclk idles 1, latency 16 cycles.
- WORD_W=16, mode 1, div=3, tx 0xBEEF loopback -> rx_data_o=0xBEEF after 128 cycles, busy_o high throughout, tx_ready_o low throughout.
- Back-to-back: tx_valid_i held high with 0x11 then 0x22, mode 2 -> second accept in the rx_valid_o cycle of the first, two rx pulses 32 cycles apart (div=1), data 0x11 then 0x22.
- Reset: assert rst_i for 1 cycle at edge 5 of a transfer -> next cycle busy_o=0, mosi_o=1, rx_valid_o never pulses, rx_data_o=0, tx_ready_o=1 one cycle after rst_i drops.
- SPI_EXCH_CS_EN: two words with cs_keep=1 then 0 -> cs_n_o low continuously across both words, high div+1 cycles after the last edge.
